// File: rtl/battle_pkg.sv
// battle_pkg: shared states, message codes, command bit indices and the attack/enemy tables.
package battle_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_STRIKE, S_WIN, S_LOSE} state_t;
    typedef enum logic [2:0] {
        M_NONE, M_HIT, M_HEAL, M_RECHARGE, M_NO_MP, M_ENEMY_HIT, M_WIN, M_LOSE
    } msg_t;
    localparam logic [2:0] CMD_ATK1 = 3'd0;
    localparam logic [2:0] CMD_ATK4 = 3'd3;
    localparam logic [2:0] CMD_HEAL = 3'd4;
    localparam logic [2:0] CMD_MAGIC = 3'd5;
    localparam logic [5:0] ATK_COST [4] = '{6'd0, 6'd5, 6'd10, 6'd20};
    localparam logic [6:0] ATK_DMG [4] = '{7'd10, 7'd15, 7'd25, 7'd40};
    localparam logic [6:0] ENEMY_DMG [4] = '{7'd8, 7'd12, 7'd16, 7'd20};
    localparam logic [5:0] HEAL_COST = 6'd10;
    localparam logic [6:0] HEAL_HP = 7'd20;
    localparam logic [5:0] RECHARGE_MP = 6'd15;
    // Index of the set bit; only meaningful for a one-hot command.
    function automatic logic [2:0] cmd_idx(input logic [5:0] c);
        cmd_idx = '0;
        for (int i = 0; i < 6; i++)
            if (c[i]) cmd_idx = 3'(i);
    endfunction
endpackage

// File: rtl/battle_if.sv
// battle_if: menu command in, player/enemy stats and game status out.
interface battle_if;
    logic [5:0] command;
    logic [6:0] player_hp;
    logic [5:0] player_mp;
    logic [6:0] enemy_hp;
    logic       busy;
    logic [2:0] msg;
    logic       win;
    logic       lose;
    modport master (output command, input player_hp, player_mp, enemy_hp, busy, msg, win, lose);
    modport slave (input command, output player_hp, player_mp, enemy_hp, busy, msg, win, lose);
endinterface

// File: rtl/stat_sat.sv
// stat_sat: saturating add (clamped to ceil_i) or subtract (clamped to 0) of a stat.
module stat_sat #(
    parameter int W = 7
) (
    input  logic [W-1:0] val_i,
    input  logic [W-1:0] delta_i,
    input  logic [W-1:0] ceil_i,
    input  logic         add_i,
    output logic [W-1:0] res_o
);
    logic [W:0] sum;
    assign sum = {1'b0, val_i} + {1'b0, delta_i};
    assign res_o = add_i ? ((sum > {1'b0, ceil_i}) ? ceil_i : sum[W-1:0])
                         : ((delta_i > val_i) ? '0 : val_i - delta_i);
endmodule

// File: rtl/battle_ctrl.sv
// battle_ctrl: turn-based battle FSM; the player acts from IDLE, then the enemy strikes
// after a fixed WAIT, until either side reaches 0 HP.
module battle_ctrl
    import battle_pkg::*;
#(
    parameter int HP_MAX = 100,
    parameter int MP_MAX = 50,
    parameter int ENEMY_DELAY = 8
) (
    input logic    clk,
    input logic    rst,
    battle_if.slave bus
);
    state_t     state_q;
    msg_t       msg_q;
    logic       armed_q;
    logic [1:0] rot_q;
    logic [7:0] cnt_q;
    logic [6:0] php_q, ehp_q, php_d, ehp_d;
    logic [5:0] pmp_q, pmp_d, cost;
    logic [2:0] idx;
    logic       accept, atk, heal, magic, mp_ok, strike;
    assign idx = cmd_idx(bus.command);
    assign accept = (state_q == S_IDLE) && armed_q && $onehot(bus.command);
    assign atk = !idx[2];
    assign heal = idx == CMD_HEAL;
    assign magic = idx == CMD_MAGIC;
    assign cost = atk ? ATK_COST[idx[1:0]] : heal ? HEAL_COST : '0;
    assign mp_ok = pmp_q >= cost;
    assign strike = state_q == S_STRIKE;
    // player_hp is healed from IDLE and damaged in STRIKE; the two never coincide.
    stat_sat #(.W(7)) u_php (
        .val_i(php_q), .delta_i(strike ? ENEMY_DMG[rot_q] : HEAL_HP),
        .ceil_i(7'(HP_MAX)), .add_i(!strike), .res_o(php_d)
    );
    stat_sat #(.W(6)) u_pmp (
        .val_i(pmp_q), .delta_i(magic ? RECHARGE_MP : cost),
        .ceil_i(6'(MP_MAX)), .add_i(magic), .res_o(pmp_d)
    );
    stat_sat #(.W(7)) u_ehp (
        .val_i(ehp_q), .delta_i(ATK_DMG[idx[1:0]]),
        .ceil_i(7'(HP_MAX)), .add_i(1'b0), .res_o(ehp_d)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            msg_q   <= M_NONE;
            armed_q <= 1'b0;
            rot_q   <= '0;
            cnt_q   <= '0;
            php_q   <= 7'(HP_MAX);
            ehp_q   <= 7'(HP_MAX);
            pmp_q   <= 6'(MP_MAX);
        end else begin
            if (bus.command == '0) armed_q <= 1'b1;
            case (state_q)
                S_IDLE: if (accept) begin
                    armed_q <= 1'b0;
                    if (!mp_ok) msg_q <= M_NO_MP;
                    else begin
                        pmp_q <= pmp_d;
                        if (atk) ehp_q <= ehp_d;
                        if (heal) php_q <= php_d;
                        msg_q <= atk ? ((ehp_d == '0) ? M_WIN : M_HIT) : heal ? M_HEAL : M_RECHARGE;
                        state_q <= (atk && ehp_d == '0) ? S_WIN : S_WAIT;
                        cnt_q <= 8'(ENEMY_DELAY - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) state_q <= S_STRIKE;
                    else cnt_q <= cnt_q - 8'd1;
                end
                S_STRIKE: begin
                    php_q   <= php_d;
                    rot_q   <= rot_q + 2'd1;
                    msg_q   <= M_ENEMY_HIT;
                    state_q <= (php_d == '0) ? S_LOSE : S_IDLE;
                end
                default: ;
            endcase
        end
    end
    assign bus.player_hp = php_q;
    assign bus.player_mp = pmp_q;
    assign bus.enemy_hp  = ehp_q;
    assign bus.msg       = msg_q;
    assign bus.busy      = state_q != S_IDLE;
    assign bus.win       = state_q == S_WIN;
    assign bus.lose      = state_q == S_LOSE;
endmodule

// File: tb/tb_battle_ctrl.sv
// tb_battle_ctrl: scoreboard bench; a behavioural model pushes the expected post-action and
// post-turn snapshots for each command, which are popped and compared as the DUT reaches them.
module tb_battle_ctrl;
    typedef struct {
        int php; int pmp; int ehp; int msg; int busy; int win; int lose; int blen;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    exp_t sb[$];
    int m_php, m_pmp, m_ehp, m_msg, m_win, m_lose, m_rot;
    int costs[4] = '{0, 5, 10, 20};
    int dmg[4] = '{10, 15, 25, 40};
    int edmg[4] = '{8, 12, 16, 20};
    battle_if bus();
    battle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask
    task automatic cmp(input string nm, input int n);
        exp_t e;
        e = sb.pop_front();
        chk({nm, ".php"}, int'(bus.player_hp), e.php);
        chk({nm, ".pmp"}, int'(bus.player_mp), e.pmp);
        chk({nm, ".ehp"}, int'(bus.enemy_hp), e.ehp);
        chk({nm, ".msg"}, int'(bus.msg), e.msg);
        chk({nm, ".busy"}, int'(bus.busy), e.busy);
        chk({nm, ".win"}, int'(bus.win), e.win);
        chk({nm, ".lose"}, int'(bus.lose), e.lose);
        if (n >= 0) chk({nm, ".busy_len"}, n, e.blen);
    endtask
    task automatic model_reset();
        m_php = 100; m_pmp = 50; m_ehp = 100; m_msg = 0; m_win = 0; m_lose = 0; m_rot = 0;
        sb.delete();
    endtask
    task automatic do_reset();
        bus.command = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk("rst.php", int'(bus.player_hp), 100);
        chk("rst.pmp", int'(bus.player_mp), 50);
        chk("rst.ehp", int'(bus.enemy_hp), 100);
        chk("rst.msg", int'(bus.msg), 0);
        chk("rst.flags", int'({bus.busy, bus.win, bus.lose}), 0);
        rst = 1'b0;
        @(negedge clk);
    endtask
    task automatic act(input string nm, input logic [5:0] cmd, input int hold);
        exp_t e;
        int i, n, cst;
        i = -1;
        for (int k = 0; k < 6; k++) if (cmd[k]) i = k;
        e = '{m_php, m_pmp, m_ehp, m_msg, (m_win || m_lose) ? 1 : 0, m_win, m_lose, 0};
        cst = (i >= 0 && i < 4) ? costs[i] : (i == 4 ? 10 : 0);
        if (m_win != 0 || m_lose != 0 || $countones(cmd) != 1) begin
            sb.push_back(e);
            sb.push_back(e);
        end else if (m_pmp < cst) begin
            m_msg = 4;
            e.msg = 4;
            sb.push_back(e);
            sb.push_back(e);
        end else begin
            m_pmp -= cst;
            if (i < 4) begin
                m_ehp = (m_ehp > dmg[i]) ? m_ehp - dmg[i] : 0;
                m_win = (m_ehp == 0) ? 1 : 0;
                m_msg = m_win ? 6 : 1;
            end else if (i == 4) begin
                m_php = (m_php + 20 > 100) ? 100 : m_php + 20;
                m_msg = 2;
            end else begin
                m_pmp = (m_pmp + 15 > 50) ? 50 : m_pmp + 15;
                m_msg = 3;
            end
            e = '{m_php, m_pmp, m_ehp, m_msg, 1, m_win, 0, 0};
            sb.push_back(e);
            if (m_win == 0) begin
                m_php = (m_php > edmg[m_rot]) ? m_php - edmg[m_rot] : 0;
                m_rot = (m_rot + 1) % 4;
                m_lose = (m_php == 0) ? 1 : 0;
                m_msg = 5;
                e = '{m_php, m_pmp, m_ehp, 5, m_lose, 0, m_lose, 9};
            end
            sb.push_back(e);
        end
        bus.command = cmd;
        @(negedge clk);
        cmp({nm, ".act"}, -1);
        n = (bus.busy && !bus.win && !bus.lose) ? 1 : 0;
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            n += (bus.busy && !bus.win && !bus.lose) ? 1 : 0;
        end
        bus.command = '0;
        for (int t = 0; t < 60 && bus.busy && !bus.win && !bus.lose; t++) begin
            @(negedge clk);
            n += (bus.busy && !bus.win && !bus.lose) ? 1 : 0;
        end
        cmp({nm, ".turn"}, n);
        @(negedge clk);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b0;
        bus.command = '0;
        @(negedge clk);
        do_reset();
        act("atk1_hold3", 6'b000001, 3);
        act("multi_bit", 6'b000011, 2);
        act("heal_sat", 6'b010000, 1);
        act("recharge_sat", 6'b100000, 1);
        for (int k = 0; k < 4; k++) act("heal_drain", 6'b010000, 1);
        act("atk2_to_mp5", 6'b000010, 1);
        act("atk3_no_mp", 6'b000100, 3);
        act("heal_no_mp", 6'b010000, 1);
        do_reset();
        act("atk4_a", 6'b001000, 1);
        act("atk4_b", 6'b001000, 1);
        act("atk3_win", 6'b000100, 1);
        act("after_win", 6'b000001, 1);
        act("after_win_heal", 6'b010000, 1);
        do_reset();
        for (int k = 0; k < 12 && m_lose == 0; k++) act("recharge_lose", 6'b100000, 1);
        act("after_lose", 6'b000001, 1);
        do_reset();
        bus.command = 6'b000001;
        repeat (3) @(negedge clk);
        bus.command = '0;
        chk("midwait.busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("midwait.php", int'(bus.player_hp), 100);
        chk("midwait.ehp", int'(bus.enemy_hp), 100);
        chk("midwait.msg", int'(bus.msg), 0);
        chk("midwait.busy_rst", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midwait.late_php", int'(bus.player_hp), 100);
        chk("midwait.late_msg", int'(bus.msg), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
